// File: rtl/bf_io_port.sv
// Byte-wide I/O responder for the brainfuck core: an output FIFO drained by the host
// and an input FIFO filled by the host, with full/empty status and sticky error flags.
module bf_io_port #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       out_wr,
   input  logic [7:0] out_data,
   output logic       out_full,
   input  logic       in_rd,
   output logic [7:0] in_data,
   output logic       in_empty,
   output logic       host_tx_valid,
   output logic [7:0] host_tx_data,
   input  logic       host_tx_ready,
   input  logic       host_rx_valid,
   input  logic [7:0] host_rx_data,
   output logic       host_rx_ready,
   output logic       out_overrun,
   output logic       in_underrun
);

   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [7:0]    omem [DEPTH];
   logic [AW-1:0] owr, ord;
   logic [AW:0]   ocnt;
   logic [7:0]    imem [DEPTH];
   logic [AW-1:0] iwr, ird;
   logic [AW:0]   icnt;

   logic o_push, o_pop, i_push, i_pop;

   // Host valid/ready: a byte moves only on an edge where valid and ready are both 1;
   // the sender holds data stable while valid=1 and ready=0. Decisions use the count
   // registered at the start of the cycle, so there is no fall-through either way.
   assign out_full      = (ocnt == CNT_FULL);
   assign host_tx_valid = (ocnt != '0);
   assign in_empty      = (icnt == '0);
   assign host_rx_ready = (icnt != CNT_FULL);

   assign o_push = out_wr && !out_full;
   assign o_pop  = host_tx_valid && host_tx_ready;
   assign i_push = host_rx_valid && host_rx_ready;
   assign i_pop  = in_rd && !in_empty;

   assign host_tx_data = host_tx_valid ? omem[ord] : 8'h00;
   assign in_data      = in_empty ? 8'h00 : imem[ird];

   // Storage carries no reset; stale contents are masked by the counts.
   always_ff @(posedge clock) begin
      if (o_push) omem[owr] <= out_data;
      if (i_push) imem[iwr] <= host_rx_data;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         owr         <= '0;
         ord         <= '0;
         ocnt        <= '0;
         iwr         <= '0;
         ird         <= '0;
         icnt        <= '0;
         out_overrun <= 1'b0;
         in_underrun <= 1'b0;
      end else begin
         if (o_push) owr <= owr + PTR_ONE;
         if (o_pop)  ord <= ord + PTR_ONE;
         if (o_push && !o_pop)      ocnt <= ocnt + CNT_ONE;
         else if (o_pop && !o_push) ocnt <= ocnt - CNT_ONE;

         if (i_push) iwr <= iwr + PTR_ONE;
         if (i_pop)  ird <= ird + PTR_ONE;
         if (i_push && !i_pop)      icnt <= icnt + CNT_ONE;
         else if (i_pop && !i_push) icnt <= icnt - CNT_ONE;

         if (out_wr && out_full) out_overrun <= 1'b1;
         if (in_rd && in_empty)  in_underrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bf_io_port.sv
// Bench for bf_io_port: directed scenarios plus random traffic, compared every cycle
// against a queue-based model of the two FIFOs and their sticky flags.
module tb_bf_io_port;

   localparam int DEPTH = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic       out_wr;
   logic [7:0] out_data;
   logic       out_full;
   logic       in_rd;
   logic [7:0] in_data;
   logic       in_empty;
   logic       host_tx_valid;
   logic [7:0] host_tx_data;
   logic       host_tx_ready;
   logic       host_rx_valid;
   logic [7:0] host_rx_data;
   logic       host_rx_ready;
   logic       out_overrun;
   logic       in_underrun;

   int checks   = 0;
   int failures = 0;

   logic [7:0] oq[$];
   logic [7:0] iq[$];
   logic       m_ovr;
   logic       m_und;

   bf_io_port #(.DEPTH(DEPTH), .AW(2)) dut (
      .clock(clock), .reset(reset),
      .out_wr(out_wr), .out_data(out_data), .out_full(out_full),
      .in_rd(in_rd), .in_data(in_data), .in_empty(in_empty),
      .host_tx_valid(host_tx_valid), .host_tx_data(host_tx_data), .host_tx_ready(host_tx_ready),
      .host_rx_valid(host_rx_valid), .host_rx_data(host_rx_data), .host_rx_ready(host_rx_ready),
      .out_overrun(out_overrun), .in_underrun(in_underrun)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      oq.delete();
      iq.delete();
      m_ovr = 1'b0;
      m_und = 1'b0;
   endtask

   // Applies this cycle's inputs to the model using the occupancy seen before the edge.
   task automatic model_edge();
      int os = oq.size();
      int is = iq.size();
      if (out_wr && os == DEPTH) m_ovr = 1'b1;
      if (in_rd && is == 0)      m_und = 1'b1;
      if (os != 0 && host_tx_ready) void'(oq.pop_front());
      if (out_wr && os != DEPTH)    oq.push_back(out_data);
      if (host_rx_valid && is != DEPTH) iq.push_back(host_rx_data);
      if (in_rd && is != 0)             void'(iq.pop_front());
   endtask

   task automatic check_all(input string tag);
      check({tag, ".out_full"},  32'(out_full),      32'(oq.size() == DEPTH));
      check({tag, ".tx_valid"},  32'(host_tx_valid), 32'(oq.size() != 0));
      check({tag, ".tx_data"},   32'(host_tx_data),  (oq.size() != 0) ? 32'(oq[0]) : 32'h0);
      check({tag, ".in_empty"},  32'(in_empty),      32'(iq.size() == 0));
      check({tag, ".rx_ready"},  32'(host_rx_ready), 32'(iq.size() != DEPTH));
      check({tag, ".in_data"},   32'(in_data),       (iq.size() != 0) ? 32'(iq[0]) : 32'h0);
      check({tag, ".overrun"},   32'(out_overrun),   32'(m_ovr));
      check({tag, ".underrun"},  32'(in_underrun),   32'(m_und));
   endtask

   task automatic step(input string tag, input logic owr, input logic [7:0] od, input logic ird,
                       input logic txr, input logic rxv, input logic [7:0] rxd);
      out_wr        = owr;
      out_data      = od;
      in_rd         = ird;
      host_tx_ready = txr;
      host_rx_valid = rxv;
      host_rx_data  = rxd;
      @(posedge clock);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic idle_inputs();
      out_wr = 0; out_data = 0; in_rd = 0;
      host_tx_ready = 0; host_rx_valid = 0; host_rx_data = 0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      idle_inputs();
      #1;
      model_clear();
      check_all("reset");
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      logic       rxv_hold;
      logic [7:0] rxd_hold;
      reset = 1'b0;
      idle_inputs();
      model_clear();
      #2;
      check_all("por");
      check("por.in_empty", 32'(in_empty), 32'h1);
      check("por.rx_ready", 32'(host_rx_ready), 32'h1);
      @(negedge clock);
      reset = 1'b1;

      // Host sends "Hi", core reads both back.
      step("hi.p0", 0, 0, 0, 0, 1, 8'h48);
      check("hi.head0", 32'(in_data), 32'h48);
      step("hi.p1", 0, 0, 0, 0, 1, 8'h69);
      step("hi.r0", 0, 0, 1, 0, 0, 0);
      check("hi.head1", 32'(in_data), 32'h69);
      step("hi.r1", 0, 0, 1, 0, 0, 0);
      check("hi.empty", 32'(in_empty), 32'h1);
      check("hi.underrun", 32'(in_underrun), 32'h0);

      // Continuous streaming through both FIFOs across pointer wrap.
      for (int i = 0; i < 16; i++)
         step("stream", 1, 8'(8'h10 + i), i != 0, i != 0, 1, 8'(8'h80 + i));
      step("stream.tail", 0, 0, 1, 1, 0, 0);
      check("stream.ovr", 32'(out_overrun), 32'h0);
      check("stream.und", 32'(in_underrun), 32'h0);

      // Overfill the output FIFO, then drain.
      for (int i = 1; i <= 5; i++) begin
         step("ovf.w", 1, 8'(i), 0, 0, 0, 0);
         if (i == 4) check("ovf.full4", 32'(out_full), 32'h1);
      end
      check("ovf.overrun", 32'(out_overrun), 32'h1);
      for (int i = 1; i <= 4; i++) begin
         check("ovf.head", 32'(host_tx_data), 32'(i));
         step("ovf.d", 0, 0, 0, 1, 0, 0);
      end
      check("ovf.valid", 32'(host_tx_valid), 32'h0);

      // Read on empty, then a later host byte.
      step("und.rd", 0, 0, 1, 0, 0, 0);
      check("und.data", 32'(in_data), 32'h0);
      check("und.flag", 32'(in_underrun), 32'h1);
      step("und.push", 0, 0, 0, 0, 1, 8'h2A);
      check("und.head", 32'(in_data), 32'h2A);
      step("und.pop", 0, 0, 1, 0, 0, 0);

      // Full output FIFO with push and pop in the same cycle.
      for (int i = 0; i < 4; i++) step("fpp.fill", 1, 8'(8'hC0 + i), 0, 0, 0, 0);
      step("fpp.both", 1, 8'hEE, 0, 1, 0, 0);
      check("fpp.notfull", 32'(out_full), 32'h0);
      check("fpp.head", 32'(host_tx_data), 32'hC1);
      for (int i = 0; i < 3; i++) step("fpp.drain", 0, 0, 0, 1, 0, 0);
      check("fpp.empty", 32'(host_tx_valid), 32'h0);

      // Reset mid-stream with three bytes buffered each way.
      do_reset();
      for (int i = 0; i < 3; i++) step("mid.fill", 1, 8'(i + 1), 0, 0, 1, 8'(i + 7));
      #3;
      reset = 1'b0;
      #1;
      model_clear();
      check_all("mid.rst");
      check("mid.tx_valid", 32'(host_tx_valid), 32'h0);
      check("mid.in_data", 32'(in_data), 32'h0);
      @(negedge clock);
      reset = 1'b1;
      step("mid.a5", 1, 8'hA5, 0, 0, 1, 8'hA5);
      check("mid.tx_a5", 32'(host_tx_data), 32'hA5);
      check("mid.in_a5", 32'(in_data), 32'hA5);

      // Random traffic; host_rx_data held while a byte is pending.
      do_reset();
      rxv_hold = 1'b0;
      rxd_hold = 8'h00;
      for (int i = 0; i < 400; i++) begin
         if (!(rxv_hold && !host_rx_ready)) begin
            rxv_hold = ($urandom_range(0, 3) != 0);
            rxd_hold = 8'($urandom);
         end
         step("rand", $urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
              $urandom_range(0, 3) == 0, rxv_hold, rxd_hold);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
